// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the command issuer and its FIFO.
// Provides the command width, the bit positions of the command fields,
// the opcode constants (OP_CAS marks compare-and-swap), the issuer state enum
// and a helper that extracts the opcode from a command word.
package alu_pkg;

  localparam int CMD_W = 12;

  // Command field positions: [11:9] opcode, [8:6] addr1, [5:3] addr2, [2:0] addr3
  localparam int OPC_MSB = 11;
  localparam int OPC_LSB = 9;
  localparam int A1_MSB  = 8;
  localparam int A1_LSB  = 6;
  localparam int A2_MSB  = 5;
  localparam int A2_LSB  = 3;
  localparam int A3_MSB  = 2;
  localparam int A3_LSB  = 0;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_CAS = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } issuer_state_e;

  function automatic logic [2:0] cmd_opcode(input logic [CMD_W-1:0] cmd);
    return cmd[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/command_issuer_if.sv
// command_issuer_if: host-side command handshake plus the controller-side
// command/syscall/done signals of the command issuer.
//   in_valid/in_cmd (host -> issuer), in_ready (issuer -> host)
//   command/syscall (issuer -> controller), done (controller -> issuer)
// Handshake: a transfer happens on a rising edge where in_valid and in_ready
// are both high; in_ready does not depend on in_valid, and the host keeps
// in_cmd stable while in_valid is high and in_ready is low.
interface command_issuer_if;
  import alu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [CMD_W-1:0] in_cmd;
  logic [CMD_W-1:0] command;
  logic             syscall;
  logic             done;

  // master: host + controller side
  modport master (
    output in_valid, in_cmd, done,
    input  in_ready, command, syscall
  );

  // slave: the issuer
  modport slave (
    input  in_valid, in_cmd, done,
    output in_ready, command, syscall
  );
endinterface

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous first-in first-out command buffer.
// Ports: clk, rst_n (async active-low), push_i/wdata_i write side,
// pop_i read side with rdata_o showing the head, full_o, empty_o.
// Push is ignored while full, pop is ignored while empty. A pushed entry is
// visible at the head only from the cycle after the push.
module cmd_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop_ok) count_d = count_q + CNT_W'(1);
    else if (pop_ok && !push_ok) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/command_issuer.sv
// command_issuer: queues host commands and issues them one at a time to an
// ALU controller, waiting for done or abandoning the command on timeout.
// Ports: clk, rst_n (async active-low); bus (command_issuer_if.slave) with the
// host handshake and command/syscall/done; err_clr clears timeout_err; busy;
// issued_count / cas_count completion counters; timeout_err sticky flag;
// dbg_state_o exposes the FSM state.
module command_issuer
  import alu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  command_issuer_if.slave     bus,
  input  logic                err_clr,
  output logic                busy,
  output logic [7:0]          issued_count,
  output logic [7:0]          cas_count,
  output logic                timeout_err,
  output issuer_state_e       dbg_state_o
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  issuer_state_e    state_q, state_d;
  logic [CMD_W-1:0] command_q, command_d;
  logic             syscall_q, syscall_d;
  logic [CW-1:0]    wait_cnt_q, wait_cnt_d;
  logic [7:0]       issued_q, issued_d;
  logic [7:0]       cas_q, cas_d;
  logic             err_q, err_d;
  logic             pop;
  logic             timeout_hit;
  logic [CMD_W-1:0] fifo_rdata;
  logic             fifo_full, fifo_empty;

  cmd_fifo #(.W(CMD_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (bus.in_valid),
    .wdata_i (bus.in_cmd),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; done takes priority over the timeout in WAIT
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!fifo_empty) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (bus.done || (wait_cnt_q == WAIT_LAST)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output / datapath logic. The head is popped while leaving IDLE so that
  // command and syscall are both registered and valid during the ISSUE cycle.
  always_comb begin
    pop         = 1'b0;
    command_d   = command_q;
    syscall_d   = 1'b0;
    wait_cnt_d  = wait_cnt_q;
    issued_d    = issued_q;
    cas_d       = cas_q;
    timeout_hit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          command_d = fifo_rdata;
          syscall_d = 1'b1;
        end
      end
      ST_ISSUE: wait_cnt_d = '0;
      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q + CW'(1);
        if (bus.done) begin
          issued_d = issued_q + 8'd1;
          if (cmd_opcode(command_q) == OP_CAS) cas_d = cas_q + 8'd1;
        end else if (wait_cnt_q == WAIT_LAST) begin
          timeout_hit = 1'b1;
        end
      end
      default: ;
    endcase
    // Setting the flag wins over a simultaneous clear
    if (timeout_hit)  err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
    else              err_d = err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      command_q  <= '0;
      syscall_q  <= 1'b0;
      wait_cnt_q <= '0;
      issued_q   <= '0;
      cas_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      command_q  <= command_d;
      syscall_q  <= syscall_d;
      wait_cnt_q <= wait_cnt_d;
      issued_q   <= issued_d;
      cas_q      <= cas_d;
      err_q      <= err_d;
    end
  end

  assign bus.in_ready  = !fifo_full;
  assign bus.command   = command_q;
  assign bus.syscall   = syscall_q;
  assign busy          = (state_q != ST_IDLE) || !fifo_empty;
  assign issued_count  = issued_q;
  assign cas_count     = cas_q;
  assign timeout_err   = err_q;
  assign dbg_state_o   = state_q;
endmodule

// File: doc/command_issuer.md
COMMAND_ISSUER -- requirements
Module: command_issuer

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO depth; power of two, at least 2.
REQ-002 Parameter TIMEOUT, default 8, maximum cycles spent in WAIT before abandoning a command; at least 4.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 in_valid  input  1  host offers in_cmd this cycle.
REQ-006 in_ready  output  1  FIFO can accept; a transfer occurs when in_valid and in_ready are both high.
REQ-007 in_cmd  input  12  host command: [11:9] opcode, [8:6] addr1, [5:3] addr2, [2:0] addr3.
REQ-008 command  output  12  registered command presented to the ALU controller.
REQ-009 syscall  output  1  registered one-cycle run pulse to the controller, aligned with a new command value.
REQ-010 done  input  1  controller reports completion of the current command (single-cycle pulse).
REQ-011 err_clr  input  1  clears timeout_err.
REQ-012 busy  output  1  high when the FSM is not in IDLE or the FIFO is non-empty.
REQ-013 issued_count  output  8  number of commands completed with done.
REQ-014 cas_count  output  8  number of completed commands with opcode 3'b111 (CAS).
REQ-015 timeout_err  output  1  sticky flag; at least one command was abandoned on timeout.

Function
REQ-016 The FIFO shall be first-in first-out; in_ready shall equal not-full, so an offer while full is not accepted and in_cmd is not stored.
REQ-017 A pushed entry shall become poppable no earlier than the cycle after the push; a push and a pop in the same cycle shall both take effect when the FIFO is neither full nor empty.
REQ-018 FSM states: IDLE, ISSUE, WAIT.
REQ-019 IDLE: if the FIFO is non-empty, the FSM shall go to ISSUE; otherwise it shall stay in IDLE.
REQ-020 Transition into ISSUE: the FSM shall pop the FIFO head, register it onto command, and assert syscall for exactly the ISSUE cycle; it then goes to WAIT unconditionally.
REQ-021 command shall hold its last issued value until the next ISSUE.
REQ-022 WAIT: a cycle counter starts at 0 on entry and increments each cycle.
REQ-023 WAIT exit on done: on the first cycle done is high, the FSM shall go to IDLE and issued_count shall increment; cas_count shall also increment if the issued opcode is 3'b111.
REQ-024 WAIT exit on timeout: if done has not been seen and the counter equals TIMEOUT-1, the FSM shall go to IDLE, set timeout_err, and leave both counts unchanged.
REQ-025 If done and the timeout condition occur in the same cycle, done shall win.
REQ-026 done shall be ignored in IDLE and ISSUE.
REQ-027 Minimum issue-to-issue spacing shall be 3 cycles (ISSUE, WAIT with done, IDLE), so back-to-back syscall pulses never occur.
REQ-028 issued_count and cas_count shall wrap from 255 to 0.
REQ-029 err_clr shall clear timeout_err on the next edge; if a timeout sets the flag in the same cycle, set shall win.

Reset
REQ-030 While rst_n is low, the FIFO shall be empty, state IDLE, command 12'h000, syscall 0, busy 0, both counts 0, timeout_err 0, in_ready 1.
REQ-031 Reset asserted mid-WAIT shall abandon the command without incrementing counts or setting timeout_err; FIFO contents shall be discarded.
REQ-032 After rst_n deasserts, syscall shall not assert before the second rising edge.

Structure
REQ-033 A shared package alu_pkg shall hold: the opcode constants (including OP_CAS = 3'b111), the command field bit positions, and the issuer state enum.
REQ-034 The FIFO shall be a separate sub-module, cmd_fifo, parameterised by width (12) and DEPTH; command_issuer instantiates it and holds the FSM, counters and flags.

Verification
REQ-035 Push 12'h0C8, with done returned 2 cycles after syscall -> one syscall pulse with command=12'h0C8; issued_count=1, cas_count=0, busy low after done.
REQ-036 Push 12'hE0A (CAS), then done -> issued_count=1, cas_count=1.
REQ-037 Push 5 commands with DEPTH=4 while done is withheld -> in_ready low after the FSM pops one and the FIFO refills; all 5 commands are issued in order once done pulses resume.
REQ-038 Push one command and never assert done -> FSM returns to IDLE after TIMEOUT cycles of WAIT; timeout_err=1, issued_count=0. A later err_clr clears the flag; err_clr coinciding with a second timeout leaves it set.
REQ-039 Assert done in the same cycle as the timeout -> counts increment and timeout_err stays 0.
REQ-040 Drop rst_n mid-WAIT with 2 entries queued -> all outputs return to their reset values, no further syscall pulses, FIFO empty.
